vga_sync_decoder: RTL

//  Receive-side counterpart of the VGA timing generator. Takes hsync/vsync from any source,

---
 rtl/vga_sync_decoder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers line/frame timing from a free-running hsync/vsync pair, rebuilds
//   pixel coordinates and reports lock once the frame timing has been stable
//   for LOCK_FRAMES consecutive frames.
// Ports
//   clk, RSTN                 pixel clock, async active-low reset
//   hsync_in, vsync_in        active-low sync pulses, may be async to clk
//   pixel_x, pixel_y, active  decoded coordinates (combinational from counters)
//   h_total, hsync_width      last line period / hsync low time, in clocks
//   v_total                   last frame length, in lines
//   frame_start               one-cycle pulse per detected vsync falling edge
//   locked                    high while the tracker is in LOCKED
module vga_sync_decoder #(
  parameter int unsigned H_START     = 144,
  parameter int unsigned V_START     = 35,
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       active,
  output logic [9:0] h_total,
  output logic [9:0] hsync_width,
  output logic [9:0] v_total,
  output logic       frame_start,
  output logic       locked
);

  localparam int unsigned CW    = 10;
  localparam int unsigned MW    = 4;
  localparam int unsigned H_END = H_START + WIDTH;
  localparam int unsigned V_END = V_START + HEIGHT;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  logic          hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d, hs_prev_q, hs_prev_d;
  logic          vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_prev_q, vs_prev_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, hw_cnt_q, hw_cnt_d;
  logic [CW-1:0] h_total_q, h_total_d, hsync_width_q, hsync_width_d;
  logic [CW-1:0] v_total_q, v_total_d;
  logic          frame_start_q, frame_start_d;
  logic          line_err_q, line_err_d;
  logic          first_q, first_d;
  logic          locked_q, locked_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  state_e        state_q, state_d;

  logic          hfall, hrise, vfall;
  logic [CW-1:0] h_period, v_period;
  logic [MW-1:0] match_inc;
  logic          h_bad, v_match, sync_lost, frame_good;
  logic          h_in, v_in;

  // Next-state logic for synchronizers, counters, measurements and tracker FSM
  always_comb begin
    hs_s1_d       = hsync_in;
    hs_s2_d       = hs_s1_q;
    hs_prev_d     = hs_s2_q;
    vs_s1_d       = vsync_in;
    vs_s2_d       = vs_s1_q;
    vs_prev_d     = vs_s2_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hw_cnt_d      = hw_cnt_q;
    h_total_d     = h_total_q;
    hsync_width_d = hsync_width_q;
    v_total_d     = v_total_q;
    line_err_d    = line_err_q;
    match_cnt_d   = match_cnt_q;
    first_d       = first_q;
    state_d       = state_q;

    hfall = hs_prev_q & ~hs_s2_q;
    hrise = ~hs_prev_q & hs_s2_q;
    vfall = vs_prev_q & ~vs_s2_q;

    // Periods saturate so a resumed stream after sync loss never wraps to 0
    h_period  = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CW'(1);
    v_period  = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + CW'(1);
    match_inc = match_cnt_q + MW'(1);
    h_bad     = hfall & (h_period != h_total_q);
    v_match   = (v_period == v_total_q);
    sync_lost = (hcnt_q == CNT_MAX) | (vcnt_q == CNT_MAX);

    // First ACQUIRE frame has only a partial v_total to compare against
    frame_good = ~line_err_q & ~h_bad & (first_q | v_match);

    // Horizontal counter and line period
    if (hfall) begin
      h_total_d = h_period;
      hcnt_d    = '0;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + CW'(1);
    end

    // Vertical counter; vfall wins over a coincident hfall
    if (vfall) begin
      v_total_d = v_period;
      vcnt_d    = '0;
    end else if (hfall && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + CW'(1);
    end

    // Hsync low-time measurement, latched on the rising edge
    if (hrise) begin
      hsync_width_d = hw_cnt_q;
      hw_cnt_d      = '0;
    end else if (!hs_s2_q && (hw_cnt_q != CNT_MAX)) begin
      hw_cnt_d = hw_cnt_q + CW'(1);
    end

    // Sticky per-frame line-period error
    if (vfall) begin
      line_err_d = 1'b0;
    end else if (h_bad) begin
      line_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (vfall) begin
          state_d     = ACQUIRE;
          match_cnt_d = '0;
          first_d     = 1'b1;
        end
      end
      ACQUIRE: begin
        if (vfall) begin
          first_d = 1'b0;
          if (frame_good) begin
            match_cnt_d = match_inc;
            if (match_inc == MW'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (h_bad || (vfall && !v_match)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sync_lost) state_d = IDLE;

    frame_start_d = vfall;
    locked_d      = (state_d == LOCKED);
  end

  // State and datapath registers; sync flops reset to the idle-high level
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      hs_s1_q       <= 1'b1;
      hs_s2_q       <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_s1_q       <= 1'b1;
      vs_s2_q       <= 1'b1;
      vs_prev_q     <= 1'b1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hw_cnt_q      <= '0;
      h_total_q     <= '0;
      hsync_width_q <= '0;
      v_total_q     <= '0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      first_q       <= 1'b0;
      locked_q      <= 1'b0;
      match_cnt_q   <= '0;
      state_q       <= IDLE;
    end else begin
      hs_s1_q       <= hs_s1_d;
      hs_s2_q       <= hs_s2_d;
      hs_prev_q     <= hs_prev_d;
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      vs_prev_q     <= vs_prev_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hw_cnt_q      <= hw_cnt_d;
      h_total_q     <= h_total_d;
      hsync_width_q <= hsync_width_d;
      v_total_q     <= v_total_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
      first_q       <= first_d;
      locked_q      <= locked_d;
      match_cnt_q   <= match_cnt_d;
      state_q       <= state_d;
    end
  end

  // Coordinate decode from registered counters, gated by lock
  always_comb begin
    h_in    = (32'(hcnt_q) >= H_START) && (32'(hcnt_q) < H_END);
    v_in    = (32'(vcnt_q) >= V_START) && (32'(vcnt_q) < V_END);
    active  = locked_q & h_in & v_in;
    pixel_x = active ? (hcnt_q - CW'(H_START)) : '0;
    pixel_y = active ? (vcnt_q - CW'(V_START)) : '0;
  end

  assign h_total     = h_total_q;
  assign hsync_width = hsync_width_q;
  assign v_total     = v_total_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;

endmodule
